// File: rtl/escaneo_teclado.sv
// -----------------------------------------------------------------------------
// escaneo_teclado
//   Scan controller for a 4x4 matrix keypad. Walks an active-low one-hot
//   column drive, samples the (pulled-up, active-low) rows through a 2-FF
//   synchronizer, debounces press and release, and reports the confirmed key
//   as {row[1:0], col[1:0]} with a one-cycle strobe.
//
//   Optional feature: define TECLADO_REPEAT_EN to enable auto-repeat of the
//   strobe while a key stays held (REPEAT_DELAY, then every REPEAT_RATE ticks).
//   Without the macro there is exactly one strobe per press.
//
// Parameters
//   SCAN_DIV        clk cycles per scan tick (column dwell), >= 4
//   DEBOUNCE_TICKS  consecutive stable ticks for press and release, >= 1
//   REPEAT_DELAY    ticks from confirm strobe to first repeat (repeat build)
//   REPEAT_RATE     ticks between later repeats, <= REPEAT_DELAY (repeat build)
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous reset, active-high
//   fila_n     in   [3:0] keypad rows, active-low, asynchronous
//   col_n      out  [3:0] column drive, one-hot active-low
//   key_idx    out  [3:0] {row, col} of the last confirmed key
//   key_valid  out  one-cycle strobe: key_idx is new (or repeated)
//   key_held   out  high from confirmed press until confirmed release
// -----------------------------------------------------------------------------
module escaneo_teclado #(
  parameter int SCAN_DIV       = 16,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] fila_n,
  output logic [3:0] col_n,
  output logic [3:0] key_idx,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  state_t           state_q,     state_d;
  logic [3:0]       fila_meta_q, fila_meta_d;
  logic [3:0]       fila_sync_q, fila_sync_d;
  logic [DIV_W-1:0] div_q,       div_d;
  logic [1:0]       col_q,       col_d;
  logic [1:0]       row_q,       row_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [3:0]       key_idx_q,   key_idx_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q,  key_held_d;

`ifdef TECLADO_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [REP_W-1:0] REP_FIRST  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_RATE);
  logic [REP_W-1:0] rep_q, rep_d, rep_inc;
`endif

  logic             tick;
  logic [3:0]       rows_low;
  logic             any_low;
  logic [1:0]       low_row;
  logic             cap_low;
  logic [CNT_W-1:0] cnt_inc;
  logic             do_confirm;
  logic             do_release;

  assign tick     = (div_q == DIV_LAST);
  assign rows_low = ~fila_sync_q;
  assign any_low  = |rows_low;
  assign cap_low  = rows_low[row_q];
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Lowest-numbered low row wins when several rows are pressed together.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (rows_low[i]) low_row = 2'(i);
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    fila_meta_d = fila_n;
    fila_sync_d = fila_meta_q;
    div_d       = tick ? '0 : div_q + DIV_W'(1);
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    key_idx_d   = key_idx_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    do_confirm  = 1'b0;
    do_release  = 1'b0;
`ifdef TECLADO_REPEAT_EN
    rep_d       = rep_q;
    rep_inc     = rep_q + REP_W'(1);
`endif

    if (tick) begin
      unique case (state_q)
        ST_SCAN: begin
          if (any_low) begin
            row_d = low_row;
            cnt_d = CNT_W'(1);
            if (DEB_LAST == CNT_W'(1)) do_confirm = 1'b1;
            else                       state_d    = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          // Same captured row must remain the winning low row; anything else
          // is treated as bounce and the capture is dropped.
          if (any_low && (low_row == row_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_LAST) do_confirm = 1'b1;
          end else begin
            state_d = ST_SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        ST_HELD: begin
          if (!cap_low) begin
            cnt_d = CNT_W'(1);
            if (DEB_LAST == CNT_W'(1)) do_release = 1'b1;
            else                       state_d    = ST_RELEASE;
          end else begin
`ifdef TECLADO_REPEAT_EN
            // Reload so the next repeat lands REPEAT_RATE ticks later.
            if (rep_inc == REP_FIRST) begin
              key_valid_d = 1'b1;
              rep_d       = REP_RELOAD;
            end else begin
              rep_d = rep_inc;
            end
`endif
          end
        end
        ST_RELEASE: begin
          // Repeat counter is left untouched here, so a re-press resumes it.
          if (cap_low) begin
            state_d = ST_HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == DEB_LAST) do_release = 1'b1;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end

    if (do_confirm) begin
      key_idx_d   = {row_d, col_q};
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
      state_d     = ST_HELD;
`ifdef TECLADO_REPEAT_EN
      rep_d       = '0;
`endif
    end

    if (do_release) begin
      key_held_d = 1'b0;
      state_d    = ST_SCAN;
      col_d      = col_q + 2'd1;
`ifdef TECLADO_REPEAT_EN
      rep_d      = '0;
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      fila_meta_q <= 4'hF;
      fila_sync_q <= 4'hF;
      div_q       <= '0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cnt_q       <= '0;
      key_idx_q   <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef TECLADO_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      fila_meta_q <= fila_meta_d;
      fila_sync_q <= fila_sync_d;
      div_q       <= div_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      key_idx_q   <= key_idx_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
`ifdef TECLADO_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col_n     = ~(4'b0001 << col_q);
  assign key_idx   = key_idx_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_escaneo_teclado.sv
// -----------------------------------------------------------------------------
// tb_escaneo_teclado
//   Directed bench for escaneo_teclado with SCAN_DIV=4, DEBOUNCE_TICKS=3,
//   REPEAT_DELAY=5, REPEAT_RATE=2. A behavioural keypad matrix pulls a row low
//   whenever a pressed key's column is driven low. Expected values are written
//   by hand into each step.
// -----------------------------------------------------------------------------
module tb_escaneo_teclado;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  fila_n;
  logic [3:0]  col_n;
  logic [3:0]  key_idx;
  logic        key_valid;
  logic        key_held;

  logic [15:0] pressed;     // bit row*4+col set = key physically down
  int          total = 0;
  int          bad   = 0;
  int          strobe_cnt = 0;
  int          cyc = 0;
  int          strobe_cyc[$];
  logic [3:0]  strobe_idx[$];
  logic [3:0]  prev_col;
  int          n_rel;

  escaneo_teclado #(
    .SCAN_DIV      (4),
    .DEBOUNCE_TICKS(3),
    .REPEAT_DELAY  (5),
    .REPEAT_RATE   (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .fila_n   (fila_n),
    .col_n    (col_n),
    .key_idx  (key_idx),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // Keypad matrix model.
  always_comb begin
    fila_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_n[c]) fila_n[r] = 1'b0;
      end
    end
  end

  // Strobe monitor: records cycle number and index of every strobe.
  always @(posedge clk) begin
    cyc++;
    if (key_valid) begin
      strobe_cnt++;
      strobe_cyc.push_back(cyc);
      strobe_idx.push_back(key_idx);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge where key_valid is seen high (bounded).
  task automatic wait_strobe(input string tag, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!key_valid && n < budget);
    check(tag, {31'd0, key_valid}, 32'd1);
  endtask

  // Returns at the negedge where key_held is seen low (bounded).
  task automatic wait_released(input string tag, input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (key_held && n < budget);
    check(tag, {31'd0, key_held}, 32'd0);
  endtask

  // Returns at the first negedge after a column step in SCAN.
  task automatic tick_sync(input string tag);
    logic [3:0] p;
    int n;
    p = col_n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (col_n == p && n < 16);
    check(tag, {31'd0, (col_n !== p)}, 32'd1);
  endtask

  initial begin
    pressed = 16'h0000;
    rst     = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values.
    check("rst_col_n",     {28'd0, col_n},   32'hE);
    check("rst_key_idx",   {28'd0, key_idx}, 32'h0);
    check("rst_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_key_held",  {31'd0, key_held},  32'd0);

    // Column dwell is exactly SCAN_DIV cycles.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("dwell_col0", {28'd0, col_n}, 32'hE);
    @(negedge clk);
    check("dwell_col1", {28'd0, col_n}, 32'hD);

    // Key '5': row 1, column 1.
    pressed[5] = 1'b1;
    wait_strobe("k5_strobe", 40);
    check("k5_idx",  {28'd0, key_idx}, 32'h5);
    check("k5_held", {31'd0, key_held}, 32'd1);
    @(negedge clk);
    check("k5_one_cycle", {31'd0, key_valid}, 32'd0);
    check("k5_count", strobe_cnt, 32'd1);
    repeat (8) @(negedge clk);
    pressed[5] = 1'b0;
    wait_released("k5_release", 40, n_rel);
    // Sync latency plus three high ticks: 11..14 cycles depending on phase.
    check("k5_release_window", {31'd0, (n_rel >= 10 && n_rel <= 15)}, 32'd1);
    check("k5_resume_col", {28'd0, col_n}, 32'hB);
    check("k5_count_after", strobe_cnt, 32'd1);

    // Bounce: row 2 low for two ticks only.
    tick_sync("bounce_sync");
    pressed = 16'h0F00;
    repeat (8) @(negedge clk);
    pressed = 16'h0000;
    repeat (40) @(negedge clk);
    check("bounce_count", strobe_cnt, 32'd1);
    check("bounce_held",  {31'd0, key_held}, 32'd0);
    tick_sync("bounce_scan_sync");
    prev_col = col_n;
    repeat (4) @(negedge clk);
    check("bounce_scan_rot", {28'd0, col_n}, {28'd0, prev_col[2:0], prev_col[3]});

    // Rows 0 and 2 together in column 3: lowest row wins.
    pressed = 16'h0808;
    wait_strobe("multi_strobe", 40);
    check("multi_idx", {28'd0, key_idx}, 32'h3);
    @(negedge clk);
    pressed = 16'h0000;
    wait_released("multi_release", 40, n_rel);

    // '*' held, then '0' pressed on top: '0' is ignored.
    pressed[12] = 1'b1;
    wait_strobe("star_strobe", 40);
    check("star_idx", {28'd0, key_idx}, 32'hC);
    pressed[13] = 1'b1;
    repeat (12) @(negedge clk);
    check("star_count",     strobe_cnt, 32'd3);
    check("star_held",      {31'd0, key_held}, 32'd1);
    check("star_idx_still", {28'd0, key_idx}, 32'hC);
    pressed = 16'h0000;
    wait_released("star_release", 40, n_rel);
    repeat (40) @(negedge clk);
    check("star_idle_count", strobe_cnt, 32'd3);
    check("star_idle_held",  {31'd0, key_held}, 32'd0);

    // Reset while DEBOUNCE cnt=2: capture at +4, cnt=2 at +8, reset at +9.5.
    tick_sync("rst_mid_sync");
    pressed = 16'h000F;
    repeat (9) @(negedge clk);
    rst     = 1'b1;
    pressed = 16'h0000;
    @(negedge clk);
    check("rst_mid_col_n",     {28'd0, col_n},   32'hE);
    check("rst_mid_key_idx",   {28'd0, key_idx}, 32'h0);
    check("rst_mid_key_valid", {31'd0, key_valid}, 32'd0);
    check("rst_mid_key_held",  {31'd0, key_held},  32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("rst_mid_no_strobe", strobe_cnt, 32'd3);

    // Hold 'D' (row 3, column 3) for about 12 ticks after the confirm strobe.
    pressed[15] = 1'b1;
    wait_strobe("d_strobe", 40);
    check("d_idx", {28'd0, key_idx}, 32'hF);
    repeat (46) @(negedge clk);
    pressed = 16'h0000;
    wait_released("d_release", 40, n_rel);
    repeat (8) @(negedge clk);
`ifdef TECLADO_REPEAT_EN
    check("d_count", strobe_cnt, 32'd8);
    if (strobe_cyc.size() >= 8) begin
      check("d_gap_first",  strobe_cyc[4] - strobe_cyc[3], 32'd20);
      check("d_gap_second", strobe_cyc[5] - strobe_cyc[4], 32'd8);
      check("d_gap_third",  strobe_cyc[6] - strobe_cyc[5], 32'd8);
      check("d_gap_fourth", strobe_cyc[7] - strobe_cyc[6], 32'd8);
      check("d_rep_idx",    {28'd0, strobe_idx[7]}, 32'hF);
    end
`else
    check("d_count", strobe_cnt, 32'd4);
`endif
    check("d_idx_final", {28'd0, key_idx}, 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
